// File: rtl/aes256_dec.sv
// -----------------------------------------------------------------------------
// aes256_dec -- iterative AES-256 decryption core (one inverse round per clock).
//
// Ports:
//   clk       input   1    rising-edge clock
//   reset     input   1    asynchronous, active-high reset
//   start     input   1    start pulse; key_in/data_in sampled on the same edge
//   key_in    input   256  cipher key, key_in[255:248] is key byte 0
//   data_in   input   128  ciphertext, data_in[127:120] is state byte 0
//   data_out  output  128  plaintext, registered, same byte order as data_in
//   ready     output  1    high while idle with a valid result in data_out
//
// Handshake: a start seen on a rising edge while the FSM is IDLE is accepted,
// samples key_in/data_in and drops ready on that edge. start is ignored in
// every other state. ready is a level: it rises on the completion edge,
// together with the new data_out, and stays high until the next accepted start.
//
// Timeline from the accepting edge T: T+1..T+7 expand the key window forward
// to w[56..63]; T+8 adds round key 14 from the registered window; T+9..T+22
// run rounds 13..0 while the window is rolled back. ready rises on T+22.
// -----------------------------------------------------------------------------
module aes256_dec (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;        // KEXP: step 0..7, DEC: round number 13..0
  logic [31:0]  w_q [8];      // 8-word key schedule window
  logic [127:0] st_q;         // cipher state

  logic [31:0]  kexp_w_d [8]; // window advanced by one 8-word group
  logic [31:0]  roll_w_d [8]; // window rolled back by one 8-word group
  logic [7:0]   rcon_f;
  logic [7:0]   rcon_b;
  logic [127:0] rk;
  logic [127:0] ark;
  logic [127:0] imc;
  logic [127:0] round_d;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and 0 -> 0): multiply together a^2, a^4, ..., a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Column is {row0, row1, row2, row3}, row0 in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // ----------------------------------------------------------- key schedule
  // Forward step k produces group k+1, whose Rcon is 2^k. Rolling back from
  // group h needs Rcon 2^(h-1); in DEC the window holds group r/2+1, so the
  // exponent is r/2.
  assign rcon_f = 8'h01 << cnt_q[2:0];
  assign rcon_b = 8'h01 << cnt_q[3:1];

  always_comb begin
    kexp_w_d[0] = w_q[0] ^ sub_word(rot_word(w_q[7])) ^ {rcon_f, 24'h000000};
    kexp_w_d[1] = w_q[1] ^ kexp_w_d[0];
    kexp_w_d[2] = w_q[2] ^ kexp_w_d[1];
    kexp_w_d[3] = w_q[3] ^ kexp_w_d[2];
    kexp_w_d[4] = w_q[4] ^ sub_word(kexp_w_d[3]);
    kexp_w_d[5] = w_q[5] ^ kexp_w_d[4];
    kexp_w_d[6] = w_q[6] ^ kexp_w_d[5];
    kexp_w_d[7] = w_q[7] ^ kexp_w_d[6];

    // Inverse: w[i-8] = w[i] ^ f(w[i-1]); word 0 needs the recovered word 7.
    roll_w_d[7] = w_q[7] ^ w_q[6];
    roll_w_d[6] = w_q[6] ^ w_q[5];
    roll_w_d[5] = w_q[5] ^ w_q[4];
    roll_w_d[4] = w_q[4] ^ sub_word(w_q[3]);
    roll_w_d[3] = w_q[3] ^ w_q[2];
    roll_w_d[2] = w_q[2] ^ w_q[1];
    roll_w_d[1] = w_q[1] ^ w_q[0];
    roll_w_d[0] = w_q[0] ^ sub_word(rot_word(roll_w_d[7])) ^ {rcon_b, 24'h000000};
  end

  // Round r uses w[4r..4r+3]: the upper half of group r/2 for odd r, the lower
  // half for even r. Group r/2 is always the rolled-back window.
  assign rk = cnt_q[0] ? {roll_w_d[4], roll_w_d[5], roll_w_d[6], roll_w_d[7]}
                       : {roll_w_d[0], roll_w_d[1], roll_w_d[2], roll_w_d[3]};

  // ----------------------------------------------------------- inverse round
  always_comb begin
    ark = '0;
    imc = '0;
    // Byte n is row n%4, column n/4; InvShiftRows reads column (col-row) mod 4.
    for (int n = 0; n < 16; n++) begin
      ark[127-8*n -: 8] =
        inv_sbox(st_q[127-8*((n % 4) + 4*(((n / 4) + 4 - (n % 4)) % 4)) -: 8]) ^
        rk[127-8*n -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
    round_d = (cnt_q == 4'd0) ? ark : imc;
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      st_q     <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      for (int k = 0; k < 8; k++) w_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < 8; k++) w_q[k] <= key_in[255-32*k -: 32];
            st_q    <= data_in;
            cnt_q   <= 4'd0;
            ready   <= 1'b0;
            state_q <= KEXP;
          end
        end
        KEXP: begin
          if (cnt_q == 4'd7) begin
            // Window now holds w[56..63]; round key 14 is its lower half.
            st_q    <= st_q ^ {w_q[0], w_q[1], w_q[2], w_q[3]};
            cnt_q   <= 4'd13;
            state_q <= DEC;
          end else begin
            for (int k = 0; k < 8; k++) w_q[k] <= kexp_w_d[k];
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DEC: begin
          st_q <= round_d;
          if (!cnt_q[0]) begin
            for (int k = 0; k < 8; k++) w_q[k] <= roll_w_d[k];
          end
          if (cnt_q == 4'd0) begin
            data_out <= round_d;
            ready    <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_dec.sv
// -----------------------------------------------------------------------------
// tb_aes256_dec -- self-checking bench for aes256_dec.
// Known-answer vectors, ignored mid-operation starts, back-to-back operation,
// asynchronous reset mid-operation, and random key/plaintext pairs encrypted
// by a table-driven AES-256 model and fed back through the decryptor.
// -----------------------------------------------------------------------------
module tb_aes256_dec;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C2 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] key_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         ready;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];

  aes256_dec dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready)
  );

  // ------------------------------------------------------- clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ scoreboard
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // S-box table from the generator walk: p steps through all non-zero
  // elements by x*3 while q tracks p^-1 by x/3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = m_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = m_xt(rc);
      end else if (i % 8 == 4) begin
        tmp = m_subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
      for (int n = 0; n < 16; n++) t[n] = s[(n % 4) + 4*(((n / 4) + (n % 4)) % 4)];
      s = t;
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // ------------------------------------------------------------ driver tasks
  // Called 1 time unit after a rising edge; the next edge accepts the start.
  // Afterwards the bus carries junk to show it was sampled only once.
  task automatic do_start(input logic [255:0] k, input logic [127:0] d);
    key_in  = k;
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    key_in  = rand256();
    data_in = rand128();
  endtask

  // Counts edges after the accepting edge until ready rises. Optional spurious
  // starts with random bus values are driven on edges ia and ib.
  task automatic wait_done(input string tag, input int ia, input int ib,
                           input logic [127:0] prev, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == ia || n == ib) begin
        key_in  = rand256();
        data_in = rand128();
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (n == 11) begin
        check({tag, "_mid_ready"}, 128'(ready), 128'd0);
        check({tag, "_mid_hold"}, data_out, prev);
      end
      if (ready) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [255:0] k, input logic [127:0] d,
                        input logic [127:0] expv, input int ia, input int ib);
    logic [127:0] prev;
    int lat;
    prev = data_out;
    exp_q.push_back(expv);
    do_start(k, d);
    check({tag, "_busy"}, 128'(ready), 128'd0);
    wait_done(tag, ia, ib, prev, lat);
    check({tag, "_latency"}, 128'(lat), 128'd22);
    check({tag, "_dout"}, data_out, exp_q.pop_front());
  endtask

  // --------------------------------------------------------- directed steps
  initial begin
    logic [255:0] k;
    logic [127:0] pt;

    build_sbox();
    reset   = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 128'(ready), 128'd0);
    check("reset_dout", data_out, 128'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 C.3 decryption
    run_op("c3", K1, C1, P1, 0, 0);

    // Same operation, started on the first ready cycle, with spurious starts
    run_op("c3_ignored_starts", K1, C1, P1, 3, 15);

    // SP800-38A vector issued on the first ready cycle; P1 must hold meanwhile
    run_op("sp800_b2b", K2, C2, P2, 0, 0);

    // Asynchronous reset in the middle of an operation
    do_start(K1, C1);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_dout", data_out, 128'd0);
    check("async_rst_ready", 128'(ready), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 128'(ready), 128'd0);
    run_op("sp800_after_rst", K2, C2, P2, 0, 0);

    // Random loopback through the reference encryptor
    for (int i = 0; i < 50; i++) begin
      k  = rand256();
      pt = rand128();
      run_op($sformatf("rand%0d", i), k, model_enc(k, pt), pt, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
